// File: rtl/pio_debounce_edge_irq_if.sv
// Lightweight-bus slave signals for the debounced PIO input port.
interface pio_debounce_edge_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_debounce_edge_irq.sv
// Memory-mapped button/switch input: 2-flop sync, per-channel counter debounce,
// selectable edge capture (W1C) and a maskable level interrupt.
module pio_debounce_edge_irq_lane #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_LVL         = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sync,
  output logic o_stable,
  output logic o_accept
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;

  assign o_stable = r_stable;
  assign o_accept = (i_sync != r_stable) && (r_cnt == CNT_MAX);

  // Any sample matching the accepted level restarts the count, so bounces reset it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= RST_LVL;
    end else if (i_sync == r_stable) begin
      r_cnt <= '0;
    end else if (o_accept) begin
      r_stable <= i_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

module pio_debounce_edge_irq #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pio_debounce_edge_irq_if.slave bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);
  logic [WIDTH-1:0] r_sync1, r_sync2;
  logic [WIDTH-1:0] w_stable, w_accept, w_set;
  logic [WIDTH-1:0] r_mask, r_edge, r_rise, r_fall;
  logic [31:0]      w_rd;
  logic             w_wr;
  logic             w_unused;

  assign w_unused = ^bus.writedata;
  assign w_wr     = bus.chipselect & ~bus.write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    pio_debounce_edge_irq_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_LVL         (RESET_LEVEL[g])
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_sync   (r_sync2[g]),
      .o_stable (w_stable[g]),
      .o_accept (w_accept[g])
    );
  end

  assign w_set = w_accept & ((r_sync2 & r_rise) | (~r_sync2 & r_fall));

  // A capture landing on the same edge as a W1C survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_edge <= '0;
      r_rise <= '0;
      r_fall <= '1;
    end else begin
      if (w_wr && bus.address == 3'd2) r_mask <= bus.writedata[WIDTH-1:0];
      if (w_wr && bus.address == 3'd4) r_rise <= bus.writedata[WIDTH-1:0];
      if (w_wr && bus.address == 3'd5) r_fall <= bus.writedata[WIDTH-1:0];
      if (w_wr && bus.address == 3'd3)
        r_edge <= (r_edge & ~bus.writedata[WIDTH-1:0]) | w_set;
      else
        r_edge <= r_edge | w_set;
    end
  end

  always_comb begin
    w_rd = '0;
    case (bus.address)
      3'd0:    w_rd[WIDTH-1:0] = w_stable;
      3'd1:    w_rd[WIDTH-1:0] = r_sync2;
      3'd2:    w_rd[WIDTH-1:0] = r_mask;
      3'd3:    w_rd[WIDTH-1:0] = r_edge;
      3'd4:    w_rd[WIDTH-1:0] = r_rise;
      3'd5:    w_rd[WIDTH-1:0] = r_fall;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= w_rd;
  end

  assign irq = |(r_edge & r_mask);
endmodule
